// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU: control codes, alu_op classes, funct7 values, FSM states.
// Pure definitions; no latency or flow-control behaviour of its own.
package alu_pkg;

  localparam logic [3:0] CTRL_AND   = 4'b0000;
  localparam logic [3:0] CTRL_OR    = 4'b0001;
  localparam logic [3:0] CTRL_ADD   = 4'b0010;
  localparam logic [3:0] CTRL_XOR   = 4'b0011;
  localparam logic [3:0] CTRL_SUB   = 4'b0110;
  localparam logic [3:0] CTRL_SLT   = 4'b0111;
  localparam logic [3:0] CTRL_SLL   = 4'b1000;
  localparam logic [3:0] CTRL_SRL   = 4'b1001;
  localparam logic [3:0] CTRL_SRA   = 4'b1010;
  localparam logic [3:0] CTRL_SLTU  = 4'b1011;
  localparam logic [3:0] CTRL_MUL   = 4'b1100;
  localparam logic [3:0] CTRL_MULHU = 4'b1101;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MUL_RUN = 1'b1
  } state_t;

  // funct3 mapping shared by R- and I-type when funct7 selects the base variant
  function automatic logic [3:0] base_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  base_ctrl = CTRL_ADD;
      3'b001:  base_ctrl = CTRL_SLL;
      3'b010:  base_ctrl = CTRL_SLT;
      3'b011:  base_ctrl = CTRL_SLTU;
      3'b100:  base_ctrl = CTRL_XOR;
      3'b101:  base_ctrl = CTRL_SRL;
      3'b110:  base_ctrl = CTRL_OR;
      default: base_ctrl = CTRL_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// ID/EX-to-EX/MEM bundle for the execute unit: instruction fields and operands in, registered result out.
// master = upstream pipeline side, slave = execute unit.
interface alu_exec_unit_if #(parameter int XLEN = 32);
  logic            valid_in;
  logic            ready;
  logic            flush;
  logic [1:0]      alu_op_id_ex;
  logic [2:0]      funct3_id_ex;
  logic [6:0]      funct7_id_ex;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;
  logic            result_valid;

  modport master (
    output valid_in, flush, alu_op_id_ex, funct3_id_ex, funct7_id_ex, operand_a, operand_b,
    input  ready, result, zero, illegal, result_valid
  );

  modport slave (
    input  valid_in, flush, alu_op_id_ex, funct3_id_ex, funct7_id_ex, operand_a, operand_b,
    output ready, result, zero, illegal, result_valid
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of alu_op/funct3/funct7 into a 4-bit ALU control code plus an illegal flag.
// Zero latency; no flow control (pure function of its inputs).
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_MEM: ctrl = CTRL_ADD;
      ALUOP_BR:  ctrl = CTRL_SUB;
      ALUOP_R: begin
        if (funct7 == F7_MULDIV) begin
          if (ENABLE_M && funct3 == 3'b000)      ctrl = CTRL_MUL;
          else if (ENABLE_M && funct3 == 3'b011) ctrl = CTRL_MULHU;
          else                                   illegal = 1'b1;
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      ctrl = CTRL_SUB;
          else if (funct3 == 3'b101) ctrl = CTRL_SRA;
          else                       illegal = 1'b1;
        end else if (funct7 == F7_BASE) begin
          ctrl = base_ctrl(funct3);
        end else begin
          illegal = 1'b1;
        end
      end
      default: begin
        // I-type: funct7 only distinguishes SRAI from SRLI; funct3=000 is always ADDI
        if (funct3 == 3'b101 && funct7 == F7_ALT) ctrl = CTRL_SRA;
        else                                      ctrl = base_ctrl(funct3);
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU with registered result; 1-cycle latency, MUL/MULHU take XLEN cycles via shift-add.
// Backpressure: ready drops for the whole multiply; flush kills accept or in-flight multiply.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  logic [3:0]        ctrl;
  logic              dec_illegal;
  logic [XLEN-1:0]   a, b, alu_res;
  logic [SHW-1:0]    shamt;
  logic              is_mul, accept;

  state_t            state;
  logic [2*XLEN-1:0] mcand, acc, acc_step;
  logic [XLEN-1:0]   mplier, mul_res;
  logic [SHW-1:0]    cnt;
  logic              mul_hi;

  alu_ctrl_decode #(.ENABLE_M(ENABLE_M)) u_dec (
    .alu_op  (bus.alu_op_id_ex),
    .funct3  (bus.funct3_id_ex),
    .funct7  (bus.funct7_id_ex),
    .ctrl    (ctrl),
    .illegal (dec_illegal)
  );

  assign a         = bus.operand_a;
  assign b         = bus.operand_b;
  assign shamt     = b[SHW-1:0];
  assign is_mul    = !dec_illegal && (ctrl == CTRL_MUL || ctrl == CTRL_MULHU);
  assign accept    = bus.valid_in && bus.ready && !bus.flush;
  assign bus.ready = (state == S_IDLE);

  always_comb begin
    alu_res = '0;
    case (ctrl)
      CTRL_AND:  alu_res = a & b;
      CTRL_OR:   alu_res = a | b;
      CTRL_ADD:  alu_res = a + b;
      CTRL_XOR:  alu_res = a ^ b;
      CTRL_SUB:  alu_res = a - b;
      CTRL_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      CTRL_SLL:  alu_res = a << shamt;
      CTRL_SRL:  alu_res = a >> shamt;
      CTRL_SRA:  alu_res = $signed(a) >>> shamt;
      CTRL_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      default:   alu_res = '0;
    endcase
  end

  // The final add is folded into the write so the last step needs no extra cycle
  assign acc_step = acc + (mplier[0] ? mcand : '0);
  assign mul_res  = mul_hi ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      bus.result       <= '0;
      bus.zero         <= 1'b0;
      bus.illegal      <= 1'b0;
      bus.result_valid <= 1'b0;
      cnt              <= '0;
      mcand            <= '0;
      mplier           <= '0;
      acc              <= '0;
      mul_hi           <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand  <= {{XLEN{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              mul_hi <= (ctrl == CTRL_MULHU);
              state  <= S_MUL_RUN;
            end else begin
              bus.result       <= dec_illegal ? '0 : alu_res;
              bus.zero         <= dec_illegal ? 1'b1 : (alu_res == '0);
              bus.illegal      <= dec_illegal;
              bus.result_valid <= 1'b1;
            end
          end
        end
        default: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
            if (cnt == SHW'(XLEN-1)) begin
              bus.result       <= mul_res;
              bus.zero         <= (mul_res == '0);
              bus.illegal      <= 1'b0;
              bus.result_valid <= 1'b1;
              state            <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: single-cycle ops, multiply latency/stall, flush, reset, illegal decode.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(32)) bus ();
  alu_exec_unit_if #(.XLEN(32)) bus_nm ();

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b0)) u_dut_nm (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nm)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] opa, input logic [31:0] opb);
    bus.alu_op_id_ex = op;
    bus.funct3_id_ex = f3;
    bus.funct7_id_ex = f7;
    bus.operand_a    = opa;
    bus.operand_b    = opb;
    bus.valid_in     = 1'b1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] opa, input logic [31:0] opb);
    drive(op, f3, f7, opa, opb);
    step();
    bus.valid_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total_cnt++;
    if ({bus.result, bus.zero, bus.illegal, bus.result_valid, bus.ready} !== {32'h0, 4'b0001}) begin
      $display("FAIL reset_state got res=%h z=%b ill=%b rv=%b rdy=%b want res=0 z=0 ill=0 rv=0 rdy=1",
               bus.result, bus.zero, bus.illegal, bus.result_valid, bus.ready);
    end else pass_cnt++;
  endtask

  task automatic test_sub_zero();
    issue(ALUOP_R, 3'b000, F7_ALT, 32'd5, 32'd7);
    total_cnt++;
    if ({bus.result, bus.zero, bus.result_valid} !== {32'hFFFF_FFFE, 1'b0, 1'b1}) begin
      $display("FAIL r_sub got res=%h z=%b rv=%b want res=fffffffe z=0 rv=1", bus.result, bus.zero, bus.result_valid);
    end else pass_cnt++;
    step();
    total_cnt++;
    if ({bus.result, bus.result_valid} !== {32'hFFFF_FFFE, 1'b0}) begin
      $display("FAIL hold_after_pulse got res=%h rv=%b want res=fffffffe rv=0", bus.result, bus.result_valid);
    end else pass_cnt++;
    issue(ALUOP_BR, 3'b000, F7_BASE, 32'h1234, 32'h1234);
    total_cnt++;
    if ({bus.result, bus.zero, bus.result_valid} !== {32'h0, 1'b1, 1'b1}) begin
      $display("FAIL branch_sub_zero got res=%h z=%b rv=%b want res=0 z=1 rv=1", bus.result, bus.zero, bus.result_valid);
    end else pass_cnt++;
  endtask

  task automatic test_shifts();
    issue(ALUOP_R, 3'b101, F7_ALT, 32'h8000_0000, 32'd4);
    total_cnt++;
    if (bus.result !== 32'hF800_0000) $display("FAIL sra got %h want f8000000", bus.result);
    else pass_cnt++;
    issue(ALUOP_R, 3'b101, F7_BASE, 32'h8000_0000, 32'd4);
    total_cnt++;
    if (bus.result !== 32'h0800_0000) $display("FAIL srl got %h want 08000000", bus.result);
    else pass_cnt++;
    issue(ALUOP_R, 3'b001, F7_BASE, 32'h0000_0003, 32'h0000_0024);
    total_cnt++;
    if (bus.result !== 32'h0000_0030) $display("FAIL sll_shamt_mask got %h want 00000030", bus.result);
    else pass_cnt++;
    issue(ALUOP_I, 3'b000, F7_ALT, 32'd3, 32'd1);
    total_cnt++;
    if ({bus.result, bus.illegal} !== {32'd4, 1'b0}) $display("FAIL itype_add got res=%h ill=%b want 4 ill=0", bus.result, bus.illegal);
    else pass_cnt++;
  endtask

  task automatic test_slt();
    issue(ALUOP_R, 3'b010, F7_BASE, 32'hFFFF_FFFF, 32'd1);
    total_cnt++;
    if ({bus.result, bus.zero} !== {32'd1, 1'b0}) $display("FAIL slt got res=%h z=%b want 1 z=0", bus.result, bus.zero);
    else pass_cnt++;
    issue(ALUOP_R, 3'b011, F7_BASE, 32'hFFFF_FFFF, 32'd1);
    total_cnt++;
    if ({bus.result, bus.zero} !== {32'd0, 1'b1}) $display("FAIL sltu got res=%h z=%b want 0 z=1", bus.result, bus.zero);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_res [3];
    exp_res[0] = 32'd2;
    exp_res[1] = 32'h0F;
    exp_res[2] = 32'h30;
    drive(ALUOP_MEM, 3'b000, F7_BASE, 32'd1, 32'd1);
    step();
    drive(ALUOP_R, 3'b100, F7_BASE, 32'hF0, 32'hFF);
    total_cnt++;
    if ({bus.result, bus.result_valid} !== {exp_res[0], 1'b1}) $display("FAIL b2b_0 got res=%h rv=%b want %h rv=1", bus.result, bus.result_valid, exp_res[0]);
    else pass_cnt++;
    step();
    drive(ALUOP_R, 3'b111, F7_BASE, 32'hF0, 32'h3C);
    total_cnt++;
    if ({bus.result, bus.result_valid} !== {exp_res[1], 1'b1}) $display("FAIL b2b_1 got res=%h rv=%b want %h rv=1", bus.result, bus.result_valid, exp_res[1]);
    else pass_cnt++;
    step();
    bus.valid_in = 1'b0;
    total_cnt++;
    if ({bus.result, bus.result_valid} !== {exp_res[2], 1'b1}) $display("FAIL b2b_2 got res=%h rv=%b want %h rv=1", bus.result, bus.result_valid, exp_res[2]);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.result_valid !== 1'b0) $display("FAIL b2b_idle got rv=%b want 0", bus.result_valid);
    else pass_cnt++;
  endtask

  task automatic test_mul();
    int  n;
    logic rdy_bad;
    issue(ALUOP_R, 3'b000, F7_MULDIV, 32'hFFFF_FFFF, 32'd2);
    // next instruction is held by upstream while the multiply runs
    drive(ALUOP_MEM, 3'b000, F7_BASE, 32'd10, 32'd20);
    n = 0;
    rdy_bad = 1'b0;
    while (bus.result_valid !== 1'b1 && n < 40) begin
      if (bus.ready !== 1'b0) rdy_bad = 1'b1;
      n++;
      step();
    end
    total_cnt++;
    if (n !== 32) $display("FAIL mul_latency got %0d stalled cycles want 32", n);
    else pass_cnt++;
    total_cnt++;
    if (rdy_bad !== 1'b0) $display("FAIL mul_ready_low got ready high during run want low");
    else pass_cnt++;
    total_cnt++;
    if ({bus.result, bus.ready, bus.zero} !== {32'hFFFF_FFFE, 1'b1, 1'b0}) begin
      $display("FAIL mul_result got res=%h rdy=%b z=%b want fffffffe rdy=1 z=0", bus.result, bus.ready, bus.zero);
    end else pass_cnt++;
    step();
    bus.valid_in = 1'b0;
    total_cnt++;
    if ({bus.result, bus.result_valid} !== {32'd30, 1'b1}) $display("FAIL held_op got res=%h rv=%b want 1e rv=1", bus.result, bus.result_valid);
    else pass_cnt++;
    issue(ALUOP_R, 3'b011, F7_MULDIV, 32'hFFFF_FFFF, 32'd2);
    n = 0;
    while (bus.result_valid !== 1'b1 && n < 40) begin
      n++;
      step();
    end
    total_cnt++;
    if ({bus.result, n} !== {32'h1, 32'd32}) $display("FAIL mulhu got res=%h after %0d want 00000001 after 32", bus.result, n);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    logic rv_seen;
    drive(ALUOP_MEM, 3'b000, F7_BASE, 32'd9, 32'd9);
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.valid_in = 1'b0;
    total_cnt++;
    if ({bus.result, bus.result_valid} !== {32'h1, 1'b0}) $display("FAIL flush_idle got res=%h rv=%b want 1 rv=0", bus.result, bus.result_valid);
    else pass_cnt++;
    issue(ALUOP_R, 3'b000, F7_MULDIV, 32'd7, 32'd9);
    rv_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (bus.result_valid !== 1'b0) rv_seen = 1'b1;
      step();
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    if (bus.result_valid !== 1'b0) rv_seen = 1'b1;
    total_cnt++;
    if ({bus.ready, rv_seen, bus.result} !== {1'b1, 1'b0, 32'h1}) begin
      $display("FAIL flush_run got rdy=%b rv_seen=%b res=%h want rdy=1 rv_seen=0 res=1", bus.ready, rv_seen, bus.result);
    end else pass_cnt++;
    issue(ALUOP_MEM, 3'b000, F7_BASE, 32'd2, 32'd2);
    total_cnt++;
    if ({bus.result, bus.result_valid} !== {32'd4, 1'b1}) $display("FAIL add_after_flush got res=%h rv=%b want 4 rv=1", bus.result, bus.result_valid);
    else pass_cnt++;
    issue(ALUOP_R, 3'b000, F7_MULDIV, 32'd7, 32'd9);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if ({bus.result, bus.zero, bus.illegal, bus.result_valid, bus.ready} !== {32'h0, 4'b0001}) begin
      $display("FAIL reset_mid_mul got res=%h z=%b ill=%b rv=%b rdy=%b want 0 0 0 0 1",
               bus.result, bus.zero, bus.illegal, bus.result_valid, bus.ready);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (bus.result_valid !== 1'b0) $display("FAIL reset_discard got rv=%b want 0", bus.result_valid);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    issue(ALUOP_R, 3'b100, F7_MULDIV, 32'd5, 32'd3);
    total_cnt++;
    if ({bus.result, bus.illegal, bus.zero, bus.result_valid} !== {32'h0, 3'b111}) begin
      $display("FAIL illegal_m_f3 got res=%h ill=%b z=%b rv=%b want 0 1 1 1", bus.result, bus.illegal, bus.zero, bus.result_valid);
    end else pass_cnt++;
    issue(ALUOP_R, 3'b001, F7_ALT, 32'd5, 32'd3);
    total_cnt++;
    if (bus.illegal !== 1'b1) $display("FAIL illegal_alt_f3 got ill=%b want 1", bus.illegal);
    else pass_cnt++;
    issue(ALUOP_R, 3'b110, F7_BASE, 32'h5, 32'h3);
    total_cnt++;
    if ({bus.result, bus.illegal} !== {32'h7, 1'b0}) $display("FAIL illegal_clear got res=%h ill=%b want 7 0", bus.result, bus.illegal);
    else pass_cnt++;
    bus_nm.alu_op_id_ex = ALUOP_R;
    bus_nm.funct3_id_ex = 3'b000;
    bus_nm.funct7_id_ex = F7_MULDIV;
    bus_nm.operand_a    = 32'd6;
    bus_nm.operand_b    = 32'd7;
    bus_nm.valid_in     = 1'b1;
    step();
    bus_nm.valid_in = 1'b0;
    total_cnt++;
    if ({bus_nm.result, bus_nm.illegal, bus_nm.zero, bus_nm.result_valid, bus_nm.ready} !== {32'h0, 4'b1111}) begin
      $display("FAIL no_m_mul got res=%h ill=%b z=%b rv=%b rdy=%b want 0 1 1 1 1",
               bus_nm.result, bus_nm.illegal, bus_nm.zero, bus_nm.result_valid, bus_nm.ready);
    end else pass_cnt++;
  endtask

  initial begin
    reset            = 1'b1;
    bus.valid_in     = 1'b0;
    bus.flush        = 1'b0;
    bus.alu_op_id_ex = 2'b00;
    bus.funct3_id_ex = 3'b000;
    bus.funct7_id_ex = 7'b0;
    bus.operand_a    = 32'h0;
    bus.operand_b    = 32'h0;
    bus_nm.valid_in     = 1'b0;
    bus_nm.flush        = 1'b0;
    bus_nm.alu_op_id_ex = 2'b00;
    bus_nm.funct3_id_ex = 3'b000;
    bus_nm.funct7_id_ex = 7'b0;
    bus_nm.operand_a    = 32'h0;
    bus_nm.operand_b    = 32'h0;
    #1;
    test_reset();
    test_sub_zero();
    test_shifts();
    test_slt();
    test_back_to_back();
    test_mul();
    test_flush();
    test_illegal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised EX-stage execute block: decodes alu_op/funct3/funct7 into a 4-bit ALU control code and computes the result.
- Registered output with a valid/ready handshake.
- Supports an optional iterative multiplier for MUL/MULHU, which stalls the pipeline through ready.
- Sits between the ID/EX pipeline register and EX/MEM.

Parameters:
- XLEN, 32, operand/result width; power of two, ≥8.
- ENABLE_M, 1, when 1 decode MUL/MULHU; when 0 those encodings are illegal.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- valid_in  in  1  ID/EX holds a valid instruction
- ready  out  1  unit can accept; equals (state==IDLE)
- flush  in  1  kill any in-flight/accepting op
- alu_op_id_ex  in  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type
- funct3_id_ex  in  3  RISC-V funct3
- funct7_id_ex  in  7  RISC-V funct7
- operand_a  in  XLEN  rs1 value
- operand_b  in  XLEN  rs2 value or immediate
- result  out  XLEN  registered result
- zero  out  1  registered (result==0)
- illegal  out  1  registered, unsupported encoding
- result_valid  out  1  one-cycle pulse per completed op

Behaviour:
- Reset (sync): state IDLE, result=0, zero=0, illegal=0, result_valid=0, counter=0, mult regs=0. Applies mid-multiply; the op is discarded.
- Control codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111
  - SLL 1000, SRL 1001, SRA 1010, SLTU 1011, MUL 1100, MULHU 1101
- Decode by alu_op:
  - 00 → ADD.
  - 01 → SUB.
  - 10, by funct3: 000 ADD, or SUB if f7=0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if f7=0100000; 110 OR; 111 AND.
  - 10 with f7=0000001 and ENABLE_M: f3 000 → MUL, f3 011 → MULHU; any other f3 is illegal.
  - 10 with any f7 other than 0000000/0100000/0000001, or 0100000 with f3∉{000,101}: illegal.
  - 11: as 10 except f3=000 is always ADD; funct7 is only consulted for f3=101 (SRA when 0100000); never M.
- Arithmetic:
  - Shift amount = operand_b[$clog2(XLEN)-1:0].
  - SLT is signed; SLTU is unsigned; result zero-extended 0/1.
  - ADD/SUB wrap modulo 2^XLEN.
- Single-cycle ops (incl. illegal): accepted when valid_in & ready & !flush.
  - Next edge: result, zero, illegal latched, result_valid=1 for one cycle. Latency 1; back-to-back every cycle.
  - Illegal → result=0, zero=1, illegal=1.
- Multiply FSM, IDLE → MUL_RUN → IDLE:
  - On accept of MUL/MULHU: latch operands, clear 2·XLEN accumulator, counter=0, go to MUL_RUN; ready=0.
  - MUL_RUN: one shift-add step per cycle (multiplicand shifted left, multiplier right), counter increments. Unsigned product.
  - After step XLEN (counter==XLEN-1): write result = product[XLEN-1:0] (MUL) or product[2XLEN-1:XLEN] (MULHU), zero, result_valid=1, return to IDLE.
  - Total latency from accept edge to result_valid: XLEN+1 cycles. ready returns high the cycle result_valid is high; a new op may be accepted that cycle.
  - valid_in is ignored while ready=0; upstream holds the instruction.
- result_valid=0 in all cycles not listed above; result/zero/illegal hold their last value.
- Flush:
  - Flush in IDLE with valid_in: not accepted, no result_valid.
  - Flush in MUL_RUN: abort to IDLE next edge; no result_valid; result unchanged.
  - Flush beats valid_in in the same cycle. Reset beats flush.

Decomposition:
- Package alu_pkg: ALU control code localparams, alu_op encodings, funct7 constants (F7_BASE 0000000, F7_ALT 0100000, F7_MULDIV 0000001), FSM state encoding.
- Sub-module alu_ctrl_decode: combinational alu_op/funct3/funct7/ENABLE_M → {ctrl[3:0], illegal}.
- Datapath, multiplier and FSM live in alu_exec_unit.

Test Plan:
1. XLEN=32, alu_op=10 f3=000 f7=0100000, a=5 b=7 → next cycle result=0xFFFFFFFE, zero=0, result_valid=1; alu_op=01 a=b=0x1234 → result=0, zero=1.
2. a=0x80000000 b=4: R f3=101 f7=0100000 → 0xF8000000; f7=0000000 → 0x08000000. I-type alu_op=11 f3=000 f7=0100000, a=3 b=1 → 4 (ADD, not SUB).
3. SLT vs SLTU, a=0xFFFFFFFF b=1 → SLT 1, SLTU 0. Back-to-back ops on 3 consecutive cycles → 3 consecutive result_valid pulses.
4. MUL a=0xFFFFFFFF b=2 → ready=0 for 32 cycles, result_valid on cycle 33 with 0xFFFFFFFE; MULHU same operands → 0x00000001. Second op held on valid_in is accepted only when ready returns.
5. Flush on 10th MUL_RUN cycle → no result_valid, ready=1 next cycle, following ADD 2+2 returns 4. Reset asserted mid-multiply → all outputs 0 next cycle.
6. f7=0000001 f3=100 → result=0, illegal=1, zero=1. ENABLE_M=0 with MUL encoding → illegal=1, latency 1.
